// File: rtl/frame_draw_ctrl.sv
`timescale 1ns/1ps
// frame_draw_ctrl
//
// Sequences the pixel passes that repaint the road background and the car
// sprite. After reset it paints the full background and then draws the car.
// After that it waits for frame ticks. Each tick can start one of two
// updates:
//   - a full repaint (background, then car), or
//   - a lane move (restore the background under the old car, then draw the
//     car at the new lane).
// Every output is registered. The controller is an FSM with the states
// StBg, StIdle, StErase and StDraw.
//
// Optional build macro:
//   LANE_DEBOUNCE_EN - a lane request is accepted only when the same value is
//                      sampled on two consecutive accepted frame ticks.
//
// Ports:
//   iClock        in   system clock, rising edge
//   iResetn       in   asynchronous active-low reset
//   iFrameTick    in   one-cycle frame-start pulse
//   lane_select   in   requested lane: 00=L1, 01=L2, 10=L3, 11=L2
//   iRedraw       in   level request for a full background repaint
//   oLdBackground out  background pass enable
//   oLdErase      out  background-restore pass over the old car rectangle
//   oLdDraw       out  car sprite pass enable
//   oCount        out  pixel index within the current pass
//   oLaneX        out  car X origin for the current erase/draw pass
//   oBusy         out  any pass active
//   oDone         out  one-cycle pulse after the last car pixel
//   oOverrun      out  sticky: a frame tick arrived while busy
module frame_draw_ctrl #(
    parameter int unsigned BG_PIXELS  = 19200,
    parameter int unsigned CAR_PIXELS = 200,
    parameter int unsigned LANE_1_X   = 40,
    parameter int unsigned LANE_2_X   = 80,
    parameter int unsigned LANE_3_X   = 120
) (
    input  logic        iClock,
    input  logic        iResetn,
    input  logic        iFrameTick,
    input  logic [1:0]  lane_select,
    input  logic        iRedraw,
    output logic        oLdBackground,
    output logic        oLdErase,
    output logic        oLdDraw,
    output logic [14:0] oCount,
    output logic [8:0]  oLaneX,
    output logic        oBusy,
    output logic        oDone,
    output logic        oOverrun
);

    typedef enum logic [1:0] {StBg, StIdle, StErase, StDraw} state_t;

    localparam logic [1:0]  LANE_L1  = 2'b00;
    localparam logic [1:0]  LANE_L2  = 2'b01;
    localparam logic [1:0]  LANE_L3  = 2'b10;
    localparam logic [14:0] BG_LAST  = 15'(BG_PIXELS - 1);
    localparam logic [14:0] CAR_LAST = 15'(CAR_PIXELS - 1);

    state_t     r_state;
    logic [1:0] r_lane;      // lane the car is currently drawn in
    logic [1:0] r_new_lane;  // lane for the next DRAW pass
    logic [1:0] w_sample;    // lane_select with 11 folded onto L2
    logic [1:0] w_accept;    // lane accepted from this tick's sample

    function automatic logic [8:0] lane_x(input logic [1:0] lane);
        case (lane)
            LANE_L1: lane_x = 9'(LANE_1_X);
            LANE_L3: lane_x = 9'(LANE_3_X);
            default: lane_x = 9'(LANE_2_X);
        endcase
    endfunction

    assign w_sample = (lane_select == 2'b11) ? LANE_L2 : lane_select;

`ifdef LANE_DEBOUNCE_EN
    logic [1:0] r_prev_sample;  // sample taken on the previous accepted tick

    // A glitch that lasts only one tick falls back to the drawn lane.
    assign w_accept = (w_sample == r_prev_sample) ? w_sample : r_lane;
`else
    assign w_accept = w_sample;
`endif

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_state       <= StBg;
            r_lane        <= LANE_L2;
            r_new_lane    <= LANE_L2;
            oLdBackground <= 1'b0;
            oLdErase      <= 1'b0;
            oLdDraw       <= 1'b0;
            oCount        <= '0;
            oLaneX        <= '0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
            oOverrun      <= 1'b0;
`ifdef LANE_DEBOUNCE_EN
            r_prev_sample <= LANE_L2;
`endif
        end else begin
            oDone <= 1'b0;
            // Ticks seen while a pass runs are dropped, only flagged.
            if (iFrameTick && oBusy) begin
                oOverrun <= 1'b1;
            end

            case (r_state)
                StBg: begin
                    if (!oLdBackground) begin
                        // First cycle out of reset: start the pass and
                        // take the power-up lane directly.
                        oLdBackground <= 1'b1;
                        oBusy         <= 1'b1;
                        oCount        <= '0;
                        r_new_lane    <= w_sample;
`ifdef LANE_DEBOUNCE_EN
                        r_prev_sample <= w_sample;
`endif
                    end else if (oCount == BG_LAST) begin
                        oLdBackground <= 1'b0;
                        oLdDraw       <= 1'b1;
                        oCount        <= '0;
                        oLaneX        <= lane_x(r_new_lane);
                        r_state       <= StDraw;
                    end else begin
                        oCount <= oCount + 15'd1;
                    end
                end

                StIdle: begin
                    if (iFrameTick) begin
`ifdef LANE_DEBOUNCE_EN
                        r_prev_sample <= w_sample;
`endif
                        if (iRedraw) begin
                            oLdBackground <= 1'b1;
                            oBusy         <= 1'b1;
                            oCount        <= '0;
                            r_new_lane    <= w_accept;
                            r_state       <= StBg;
                        end else if (w_accept != r_lane) begin
                            oLdErase   <= 1'b1;
                            oBusy      <= 1'b1;
                            oCount     <= '0;
                            oLaneX     <= lane_x(r_lane);
                            r_new_lane <= w_accept;
                            r_state    <= StErase;
                        end
                    end
                end

                StErase: begin
                    if (oCount == CAR_LAST) begin
                        oLdErase <= 1'b0;
                        oLdDraw  <= 1'b1;
                        oCount   <= '0;
                        oLaneX   <= lane_x(r_new_lane);
                        r_state  <= StDraw;
                    end else begin
                        oCount <= oCount + 15'd1;
                    end
                end

                StDraw: begin
                    if (oCount == CAR_LAST) begin
                        oLdDraw <= 1'b0;
                        oBusy   <= 1'b0;
                        oCount  <= '0;
                        oDone   <= 1'b1;
                        r_lane  <= r_new_lane;
                        r_state <= StIdle;
                    end else begin
                        oCount <= oCount + 15'd1;
                    end
                end

                default: r_state <= StBg;
            endcase
        end
    end

endmodule

// File: doc/frame_draw_ctrl.md
FRAME_DRAW_CTRL -- requirements
Module: frame_draw_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): BG_PIXELS, 19200, background pixel count (160x120).
REQ-002 The block SHALL expose these parameters (name, default, meaning): CAR_PIXELS, 200, car sprite pixel count (10x20).
REQ-003 The block SHALL expose these parameters (name, default, meaning): LANE_1_X/LANE_2_X/LANE_3_X, 40/80/120, lane X origins.
REQ-004 The block SHALL have the port iClock, input, 1, system clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port iResetn, input, 1, asynchronous, active-low reset.
REQ-006 The block SHALL have the port iFrameTick, input, 1, one-cycle frame-start pulse.
REQ-007 The block SHALL have the port lane_select, input, 2, requested lane; 00=L1, 01=L2, 10=L3, 11=L2.
REQ-008 The block SHALL have the port iRedraw, input, 1, level request for a full background repaint.
REQ-009 The block SHALL have the port oLdBackground, output, 1, datapath background-pass enable.
REQ-010 The block SHALL have the port oLdErase, output, 1, enable for the background-restore pass over the old car rectangle.
REQ-011 The block SHALL have the port oLdDraw, output, 1, car sprite pass enable.
REQ-012 The block SHALL have the port oCount, output, 15, pixel index within the current pass.
REQ-013 The block SHALL have the port oLaneX, output, 9, car X origin for the current pass.
REQ-014 The block SHALL have the ports oBusy, oDone and oOverrun, each output, 1: pass active; one-cycle end-of-update pulse; sticky missed-tick flag.

Function
REQ-015 The FSM states SHALL be BG, IDLE, ERASE and DRAW; every output SHALL be registered.
REQ-016 At most one of oLdBackground, oLdErase and oLdDraw SHALL be high in any cycle; oBusy SHALL equal their OR.
REQ-017 Each pass SHALL assert its enable for exactly N consecutive cycles (N=BG_PIXELS for BG, CAR_PIXELS for ERASE/DRAW), with oCount stepping 0..N-1.
REQ-018 oCount SHALL return to 0 in the cycle after the last pixel of a pass, with no gap cycle inside a pass.
REQ-019 On leaving BG, the FSM SHALL enter DRAW directly, with oLaneX set to the current lane's X.
REQ-020 In IDLE, an iFrameTick with iRedraw=1 SHALL enter BG on the next cycle; iRedraw takes priority over a lane change.
REQ-021 In IDLE, an iFrameTick with the accepted lane not equal to the drawn lane SHALL enter ERASE (oLaneX=old X), then DRAW (oLaneX=new X) back-to-back.
REQ-022 In IDLE, an iFrameTick with an unchanged lane and iRedraw=0 SHALL keep the FSM in IDLE and SHALL NOT pulse oDone.
REQ-023 The drawn-lane register SHALL update to the new lane on the last DRAW cycle.
REQ-024 oDone SHALL pulse for one cycle in the cycle after the last DRAW pixel, and the FSM SHALL then be in IDLE.
REQ-025 lane_select SHALL be sampled only on the iFrameTick cycle, so changes during a pass do not affect that pass.
REQ-026 An iFrameTick while oBusy=1 SHALL be ignored and SHALL set oOverrun, which clears only on reset.
REQ-027 A tick arriving in the same cycle as the IDLE entry SHALL be treated as arriving in IDLE, not as an overrun.

Reset
REQ-028 Asserting iResetn=0 SHALL immediately clear every output to 0, set the drawn lane to L2, and select BG, including when asserted mid-pass.
REQ-029 On the first clock after reset release, oLdBackground SHALL be 1 with oCount=0; the power-up sequence SHALL be BG then DRAW at LANE_2_X unless lane_select differs.
REQ-030 At power-up, lane_select SHALL be sampled on the first BG cycle.

Configuration
REQ-031 With LANE_DEBOUNCE_EN defined, a new lane SHALL be accepted only after the same lane_select value is sampled on two consecutive iFrameTicks; a single-tick glitch SHALL cause no update.
REQ-032 Without LANE_DEBOUNCE_EN, lane_select SHALL be accepted on the first iFrameTick sample.

Verification
REQ-033 Release reset with lane_select=01 -> oLdBackground high for 19200 cycles, then oLdDraw high for 200 cycles with oLaneX=80, then oDone pulses once.
REQ-034 In IDLE with the car drawn at L1, pulse iFrameTick with lane_select=10 (no debounce) -> 200 ERASE cycles at oLaneX=40, then 200 DRAW cycles at oLaneX=120, then oDone.
REQ-035 Pulse iFrameTick mid-DRAW -> oOverrun=1, and the pass length remains exactly 200 cycles.
REQ-036 Assert iRedraw=1 with a lane change at the same tick -> BG 19200 cycles, then DRAW at the new lane, with no ERASE.
REQ-037 Assert reset at BG pixel 5000 -> all outputs 0 asynchronously; after release, BG restarts at oCount=0.
REQ-038 With LANE_DEBOUNCE_EN, drive lane_select 00 for one tick then 01 (current lane L2) -> no ERASE/DRAW; drive 00 for two ticks -> update at the second tick.
